// File: rtl/wishbone_classic_master_if.sv
// Bus bundle for wishbone_classic_master: the user-side request/completion
// handshake plus the Wishbone classic master signals.
//   master modport : the view of wishbone_classic_master
//   slave  modport : the view of whatever drives requests and answers the bus
// Parameters: ADDRESS_WIDTH (address bits), BUS_WIDTH (data bytes).
interface wishbone_classic_master_if #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned BUS_WIDTH     = 4
);
  // user side
  logic                     up_rreq;
  logic [ADDRESS_WIDTH-1:0] up_raddr;
  logic                     up_rack;
  logic [BUS_WIDTH*8-1:0]   up_rdata;
  logic                     up_wreq;
  logic [ADDRESS_WIDTH-1:0] up_waddr;
  logic [BUS_WIDTH*8-1:0]   up_wdata;
  logic                     up_wack;
  logic                     up_err;
  // Wishbone side
  logic                     m_wb_cyc;
  logic                     m_wb_stb;
  logic                     m_wb_we;
  logic [ADDRESS_WIDTH-1:0] m_wb_addr;
  logic [BUS_WIDTH*8-1:0]   m_wb_data_o;
  logic [3:0]               m_wb_sel;
  logic [2:0]               m_wb_cti;
  logic [1:0]               m_wb_bte;
  logic [BUS_WIDTH*8-1:0]   m_wb_data_i;
  logic                     m_wb_ack;
  logic                     m_wb_err;

  modport master (
    input  up_rreq, up_raddr, up_wreq, up_waddr, up_wdata,
    input  m_wb_data_i, m_wb_ack, m_wb_err,
    output up_rack, up_rdata, up_wack, up_err,
    output m_wb_cyc, m_wb_stb, m_wb_we, m_wb_addr, m_wb_data_o, m_wb_sel, m_wb_cti, m_wb_bte
  );

  modport slave (
    output up_rreq, up_raddr, up_wreq, up_waddr, up_wdata,
    output m_wb_data_i, m_wb_ack, m_wb_err,
    input  up_rack, up_rdata, up_wack, up_err,
    input  m_wb_cyc, m_wb_stb, m_wb_we, m_wb_addr, m_wb_data_o, m_wb_sel, m_wb_cti, m_wb_bte
  );
endinterface

// File: rtl/wishbone_classic_master.sv
// Single-outstanding Wishbone classic master. Turns one-cycle read/write
// request pulses into single Wishbone classic cycles and reports completion
// with one-cycle up_rack/up_wack pulses (up_err alongside on bus error).
// A write and a read requested in the same idle cycle run write-first; the
// read address waits in a one-entry pending slot.
// Ports:
//   clk  : clock, rising edge
//   rstn : synchronous active-low reset
//   bus  : wishbone_classic_master_if.master (user handshake + Wishbone bus)
// Optional feature: define WB_TIMEOUT_EN to abort a bus cycle as an error after
// TIMEOUT_CYCLES cycles of stb without ack/err. Undefined: wait forever.
module wishbone_classic_master #(
  parameter int unsigned ADDRESS_WIDTH  = 32,
  parameter int unsigned BUS_WIDTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                             clk,
  input  logic                             rstn,
  wishbone_classic_master_if.master        bus
);
  localparam int unsigned DataW = BUS_WIDTH * 8;

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StDone} state_e;

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DataW-1:0]         wdata_q, wdata_d;
  logic [DataW-1:0]         rdata_q, rdata_d;
  logic                     pend_q, pend_d;
  logic [ADDRESS_WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic                     is_write_q, is_write_d;
  logic                     err_q, err_d;
  logic                     on_bus;
  logic                     timed_out;

  assign on_bus = (state_q == StWrite) || (state_q == StRead);

`ifdef WB_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Held at zero off the bus so every new cycle starts counting from zero.
  always_comb begin
    cnt_d     = '0;
    timed_out = 1'b0;
    if (on_bus && !bus.m_wb_ack && !bus.m_wb_err) begin
      if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
        timed_out = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timed_out = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    is_write_d  = is_write_q;
    err_d       = err_q;
    unique case (state_q)
      StIdle: begin
        if (bus.up_wreq) begin
          state_d    = StWrite;
          addr_d     = bus.up_waddr;
          wdata_d    = bus.up_wdata;
          is_write_d = 1'b1;
          if (bus.up_rreq && !pend_q) begin
            pend_d      = 1'b1;
            pend_addr_d = bus.up_raddr;
          end
        end else if (pend_q) begin
          // Deferred read goes ahead of any new read request.
          state_d    = StRead;
          addr_d     = pend_addr_q;
          pend_d     = 1'b0;
          is_write_d = 1'b0;
        end else if (bus.up_rreq) begin
          state_d    = StRead;
          addr_d     = bus.up_raddr;
          is_write_d = 1'b0;
        end
      end
      StWrite, StRead: begin
        if (bus.m_wb_ack || bus.m_wb_err || timed_out) begin
          state_d = StDone;
          // err wins over a simultaneous ack
          err_d   = bus.m_wb_err || timed_out;
          if (state_q == StRead) begin
            rdata_d = (bus.m_wb_err || timed_out) ? '0 : bus.m_wb_data_i;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      is_write_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      is_write_q  <= is_write_d;
      err_q       <= err_d;
    end
  end

  // All outputs decode registered state, so they are glitch-free and drop on reset.
  assign bus.m_wb_cyc    = on_bus;
  assign bus.m_wb_stb    = on_bus;
  assign bus.m_wb_we     = (state_q == StWrite);
  assign bus.m_wb_addr   = addr_q;
  assign bus.m_wb_data_o = wdata_q;
  assign bus.m_wb_sel    = 4'b1111;
  assign bus.m_wb_cti    = 3'b000;
  assign bus.m_wb_bte    = 2'b00;

  assign bus.up_wack  = (state_q == StDone) && is_write_q;
  assign bus.up_rack  = (state_q == StDone) && !is_write_q;
  assign bus.up_err   = (state_q == StDone) && err_q;
  assign bus.up_rdata = rdata_q;
endmodule
